// File: rtl/controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen;
  logic       irwrite;
  logic       regwrite;
  logic       memwrite;
  logic       alusrca;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] alusrcb;
  logic [1:0] pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;
  logic       done;
  logic       illegal;

  // Controller side
  modport master (
    input  op, funct, zero,
    output pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
    output alusrcb, pcsrc, alucontrol, state, done, illegal
  );

  // Datapath side
  modport slave (
    output op, funct, zero,
    input  pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst,
    input  alusrcb, pcsrc, alucontrol, state, done, illegal
  );
endinterface

// File: rtl/controller.sv
// Multicycle MIPS-subset main controller: Moore FSM plus ALU decoder.
module controller (
  input logic         clk,
  input logic         reset,
  controller_if.master bus
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRd    = 4'd3,
    StMemWb    = 4'd4,
    StMemWr    = 4'd5,
    StExecute  = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StAddiExec = 4'd9,
    StAddiWb   = 4'd10,
    StJump     = 4'd11
  } state_e;

  localparam logic [5:0] OpLw   = 6'b100011;
  localparam logic [5:0] OpSw   = 6'b101011;
  localparam logic [5:0] OpR    = 6'b000000;
  localparam logic [5:0] OpBeq  = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000;
  localparam logic [5:0] OpJ    = 6'b000010;

  state_e state_q, state_d;

  logic       pcwrite;
  logic       branch;
  logic [1:0] aluop;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic       memwrite_raw;
  logic       done_raw;
  logic       illegal_raw;

  // State register; reset snaps back to FETCH regardless of clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (bus.op)
          OpLw, OpSw: state_d = StMemAdr;
          OpR:        state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiExec;
          OpJ:        state_d = StJump;
          default:    state_d = StFetch;
        endcase
      end
      StMemAdr:   state_d = (bus.op == OpLw) ? StMemRd : StMemWr;
      StMemRd:    state_d = StMemWb;
      StExecute:  state_d = StAluWb;
      StAddiExec: state_d = StAddiWb;
      default:    state_d = StFetch;
    endcase
  end

  // Per-state control outputs (unlisted signals stay 0)
  always_comb begin
    pcwrite      = 1'b0;
    branch       = 1'b0;
    aluop        = 2'b00;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memwrite_raw = 1'b0;
    done_raw     = 1'b0;
    illegal_raw  = 1'b0;
    bus.alusrca  = 1'b0;
    bus.iord     = 1'b0;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.pcsrc    = 2'b00;
    case (state_q)
      StFetch: begin
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        bus.alusrcb = 2'b01;
      end
      StDecode: begin
        bus.alusrcb = 2'b11;
        // Only the opcodes with a defined execution path are legal
        case (bus.op)
          OpLw, OpSw, OpR, OpBeq, OpAddi, OpJ: illegal_raw = 1'b0;
          default:                             illegal_raw = 1'b1;
        endcase
      end
      StMemAdr, StAddiExec: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      StMemRd: bus.iord = 1'b1;
      StMemWb: begin
        bus.memtoreg = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      StMemWr: begin
        bus.iord     = 1'b1;
        memwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      StExecute: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b10;
      end
      StAluWb: begin
        bus.regdst   = 1'b1;
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      StAddiWb: begin
        regwrite_raw = 1'b1;
        done_raw     = 1'b1;
      end
      StBranch: begin
        bus.alusrca = 1'b1;
        aluop       = 2'b01;
        bus.pcsrc   = 2'b01;
        branch      = 1'b1;
        done_raw    = 1'b1;
      end
      StJump: begin
        bus.pcsrc = 2'b10;
        pcwrite   = 1'b1;
        done_raw  = 1'b1;
      end
      default: ;
    endcase
  end

  // ALU decoder; funct only matters for R-type execution
  always_comb begin
    bus.alucontrol = 3'b010;
    case (aluop)
      2'b01: bus.alucontrol = 3'b110;
      2'b10: begin
        case (bus.funct)
          6'b100010: bus.alucontrol = 3'b110;
          6'b100100: bus.alucontrol = 3'b000;
          6'b100101: bus.alucontrol = 3'b001;
          6'b101010: bus.alucontrol = 3'b111;
          default:   bus.alucontrol = 3'b010;
        endcase
      end
      default: bus.alucontrol = 3'b010;
    endcase
  end

  // Side-effecting strobes are masked while reset is held, since FETCH would otherwise fire them
  always_comb begin
    bus.pcen     = reset & (pcwrite | (branch & bus.zero));
    bus.irwrite  = reset & irwrite_raw;
    bus.regwrite = reset & regwrite_raw;
    bus.memwrite = reset & memwrite_raw;
    bus.done     = reset & done_raw;
    bus.illegal  = reset & illegal_raw;
    bus.state    = state_q;
  end

endmodule

// File: tb/tb_controller.sv
// Directed bench for the multicycle controller; checks state code and full control bundle.
module tb_controller;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  controller_if bus ();

  controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcen irwrite regwrite memwrite alusrca iord memtoreg regdst, alusrcb, pcsrc, alucontrol,
  //  done illegal}
  logic [16:0] ctl;
  assign ctl = {bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.alusrca, bus.iord,
                bus.memtoreg, bus.regdst, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.done,
                bus.illegal};

  localparam logic [16:0] CRst    = 17'b00000000_01_00_010_00;
  localparam logic [16:0] CFetch  = 17'b11000000_01_00_010_00;
  localparam logic [16:0] CDec    = 17'b00000000_11_00_010_00;
  localparam logic [16:0] CDecIll = 17'b00000000_11_00_010_01;
  localparam logic [16:0] CMemAdr = 17'b00001000_10_00_010_00;
  localparam logic [16:0] CMemRd  = 17'b00000100_00_00_010_00;
  localparam logic [16:0] CMemWb  = 17'b00100010_00_00_010_10;
  localparam logic [16:0] CMemWr  = 17'b00010100_00_00_010_10;
  localparam logic [16:0] CExSlt  = 17'b00001000_00_00_111_00;
  localparam logic [16:0] CExOr   = 17'b00001000_00_00_001_00;
  localparam logic [16:0] CAluWb  = 17'b00100001_00_00_010_10;
  localparam logic [16:0] CBrT    = 17'b10001000_00_01_110_10;
  localparam logic [16:0] CBrN    = 17'b00001000_00_01_110_10;
  localparam logic [16:0] CAddiWb = 17'b00100000_00_00_010_10;
  localparam logic [16:0] CJump   = 17'b10000000_00_10_010_10;

  task automatic chk(input string tag, input logic [3:0] st, input logic [16:0] c);
    total++;
    assert (bus.state === st) else begin
      bad++;
      $error("FAIL %s state got=%0d want=%0d", tag, bus.state, st);
    end
    total++;
    assert (ctl === c) else begin
      bad++;
      $error("FAIL %s ctl got=%b want=%b", tag, ctl, c);
    end
  endtask

  // Advance one cycle and sample mid-low-phase
  task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] c);
    @(negedge clk);
    #1;
    chk(tag, st, c);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.op    = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;
    #2;
    chk("reset_hold", 4'd0, CRst);

    // lw
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("lw_fetch", 4'd0, CFetch);
    cyc("lw_decode", 4'd1, CDec);
    cyc("lw_memadr", 4'd2, CMemAdr);
    cyc("lw_memrd", 4'd3, CMemRd);
    cyc("lw_memwb", 4'd4, CMemWb);
    cyc("lw_end", 4'd0, CFetch);

    // R-type slt
    bus.op    = 6'b000000;
    bus.funct = 6'b101010;
    cyc("slt_decode", 4'd1, CDec);
    cyc("slt_exec", 4'd6, CExSlt);
    cyc("slt_aluwb", 4'd7, CAluWb);
    cyc("slt_end", 4'd0, CFetch);

    // R-type or
    bus.funct = 6'b100101;
    cyc("or_decode", 4'd1, CDec);
    cyc("or_exec", 4'd6, CExOr);
    cyc("or_aluwb", 4'd7, CAluWb);
    cyc("or_end", 4'd0, CFetch);

    // beq taken, then zero drops inside the BRANCH cycle
    bus.op   = 6'b000100;
    bus.zero = 1'b1;
    cyc("beqt_decode", 4'd1, CDec);
    cyc("beqt_branch", 4'd8, CBrT);
    bus.zero = 1'b0;
    #1;
    chk("beqt_zero_drop", 4'd8, CBrN);
    cyc("beqt_end", 4'd0, CFetch);

    // beq not taken
    cyc("beqn_decode", 4'd1, CDec);
    cyc("beqn_branch", 4'd8, CBrN);
    #3;
    chk("beqn_branch_late", 4'd8, CBrN);
    cyc("beqn_end", 4'd0, CFetch);

    // sw
    bus.op = 6'b101011;
    cyc("sw_decode", 4'd1, CDec);
    cyc("sw_memadr", 4'd2, CMemAdr);
    cyc("sw_memwr", 4'd5, CMemWr);
    cyc("sw_end", 4'd0, CFetch);

    // addi; funct must not leak into alucontrol
    bus.op    = 6'b001000;
    bus.funct = 6'b100010;
    cyc("addi_decode", 4'd1, CDec);
    cyc("addi_exec", 4'd9, CMemAdr);
    cyc("addi_wb", 4'd10, CAddiWb);
    cyc("addi_end", 4'd0, CFetch);

    // j
    bus.op = 6'b000010;
    cyc("j_decode", 4'd1, CDec);
    cyc("j_jump", 4'd11, CJump);
    cyc("j_end", 4'd0, CFetch);

    // unsupported opcode
    bus.op = 6'b111111;
    cyc("ill_decode", 4'd1, CDecIll);
    cyc("ill_end", 4'd0, CFetch);

    // asynchronous reset during lw MEMRD
    bus.op = 6'b100011;
    cyc("rst_decode", 4'd1, CDec);
    cyc("rst_memadr", 4'd2, CMemAdr);
    cyc("rst_memrd", 4'd3, CMemRd);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_async", 4'd0, CRst);
    @(posedge clk);
    #1;
    chk("rst_held_edge", 4'd0, CRst);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_release", 4'd0, CFetch);
    cyc("rst_decode2", 4'd1, CDec);
    cyc("rst_memadr2", 4'd2, CMemAdr);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low (0 = reset asserted).
REQ-003 SHALL have ports op and funct, inputs, 6 bits each: instr[31:26] and instr[5:0] from the datapath.
REQ-004 SHALL have port zero, input, 1 bit: ALU zero flag.
REQ-005 SHALL have 1-bit outputs pcen, irwrite, regwrite, memwrite, alusrca, iord, memtoreg, regdst: datapath control.
REQ-006 SHALL have outputs alusrcb (2 bits), pcsrc (2 bits) and alucontrol (3 bits): datapath mux and ALU select.
REQ-007 SHALL have outputs state (4 bits), done (1 bit) and illegal (1 bit): FSM state code, instruction-retire pulse and unsupported-opcode pulse.

Function
REQ-008 SHALL be a Moore FSM with 4-bit state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11.
REQ-009 SHALL use these transitions:
- FETCH->DECODE.
- DECODE by op: 100011/101011->MEMADR; 000000->EXECUTE; 000100->BRANCH; 001000->ADDIEXEC; 000010->JUMP; any other op->FETCH.
- MEMADR->MEMRD if op=100011, else MEMWR.
- MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEXEC->ADDIWB.
- MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
- Codes 12-15->FETCH.
REQ-010 SHALL drive outputs as a function of state only, except pcen; every signal not listed for a state is 0:
- FETCH: irwrite=1, pcwrite=1, alusrcb=01, aluop=00.
- DECODE: alusrcb=11, aluop=00.
- MEMADR and ADDIEXEC: alusrca=1, alusrcb=10, aluop=00.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- EXECUTE: alusrca=1, aluop=10.
- ALUWB: regdst=1, regwrite=1.
- ADDIWB: regwrite=1.
- BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
- JUMP: pcsrc=10, pcwrite=1.
REQ-011 SHALL compute pcen = pcwrite OR (branch AND zero), combinationally; a zero change in BRANCH is reflected in pcen in the same cycle.
REQ-012 SHALL decode alucontrol from the internal 2-bit aluop:
- aluop 00 -> 010 (add); 01 -> 110 (sub).
- aluop 10, by funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
- aluop 11 (unused) -> 010.
REQ-013 SHALL assert done for exactly one cycle in the last state of each supported instruction: MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP.
REQ-014 SHALL assert illegal for exactly one cycle in DECODE when op is unsupported; done SHALL stay 0 for that instruction.
REQ-015 SHALL give instruction lengths in cycles, FETCH to last state inclusive: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unsupported 2.
REQ-016 SHALL sample op in DECODE and MEMADR only; funct SHALL be used only while aluop=10.

Reset
REQ-017 SHALL force state to FETCH immediately when reset goes 0, independent of clk, including mid-instruction.
REQ-018 SHALL, while reset=0, force pcen, irwrite, regwrite, memwrite, done and illegal to 0; all other outputs SHALL take their FETCH values (alusrcb=01, alucontrol=010, all other outputs 0), and state SHALL read 0.
REQ-019 SHALL execute FETCH on the first rising clk edge after reset returns to 1, with pcen=1 and irwrite=1 during that cycle.

Verification
REQ-020 SHALL pass this scenario: release reset, op=100011 held -> states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4; done=1 only in state 4.
REQ-021 SHALL pass this scenario: op=000000, funct=101010 -> in EXECUTE alucontrol=111 and aluop path active; in ALUWB regdst=1 and regwrite=1; 4 cycles total.
REQ-022 SHALL pass this scenario: op=000100, zero=1 in BRANCH -> pcen=1, pcsrc=01, alucontrol=110; repeated with zero=0 -> pcen=0 for the whole BRANCH cycle.
REQ-023 SHALL pass this scenario: op=101011 -> states 0,1,2,5,0; memwrite=1 and iord=1 in state 5 only; regwrite never 1.
REQ-024 SHALL pass this scenario: op=111111 -> states 0,1,0; illegal=1 in state 1; done, regwrite and memwrite never 1.
REQ-025 SHALL pass this scenario: reset driven to 0 between clock edges while in MEMRD during lw -> state=0 at once with pcen=irwrite=regwrite=memwrite=0; after release, the next cycle shows FETCH with pcen=1.
